stopwatch_btn_cond: RTL and testbench

- Front end of the stopwatch control path. It turns four raw, asynchronous, bouncy push-button levels into clean single-cycle command strobes `onestart`, `tenstart`, `pause` and `clr`.
- Those strobes feed the stopwatch mode state machine.
- Each button gets three stages in order: a 2-flop synchronizer, a saturating debounce filter, and rising-edge detection.
- A fixed-priority arbiter then guarantees that at most one strobe is asserted per cycle.

---
 rtl/stopwatch_btn_cond.sv | 95 +++++++++
 tb/tb_stopwatch_btn_cond.sv | 136 +++++++++++++
 2 files changed

// File: rtl/stopwatch_btn_cond.sv
// Stopwatch button conditioning: sync, debounce and rising-edge strobes.
// At most one command strobe per cycle, priority clr > pause > tenstart > onestart.
module stopwatch_btn_cond #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       btn_onestart_raw,
    input  logic       btn_tenstart_raw,
    input  logic       btn_pause_raw,
    input  logic       btn_clr_raw,
    output logic       onestart,
    output logic       tenstart,
    output logic       pause,
    output logic       clr,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       w_raw;
    logic [3:0]       w_rise;
    logic [3:0]       w_grant;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_db;
    logic [3:0]       r_db_q;
    logic [3:0]       r_strb;
    logic [CNT_W-1:0] r_cnt [4];

    assign w_raw = {btn_clr_raw, btn_pause_raw,
                    btn_tenstart_raw, btn_onestart_raw};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count only while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_db <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_rise = r_db & ~r_db_q;

    always_comb begin
        w_grant = 4'b0000;
        priority case (1'b1)
            w_rise[3]: w_grant = 4'b1000;
            w_rise[2]: w_grant = 4'b0100;
            w_rise[1]: w_grant = 4'b0010;
            w_rise[0]: w_grant = 4'b0001;
            default:   w_grant = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_db_q <= '0;
            r_strb <= '0;
        end else begin
            r_db_q <= r_db;
            r_strb <= w_grant;
        end
    end

    assign onestart = r_strb[0];
    assign tenstart = r_strb[1];
    assign pause    = r_strb[2];
    assign clr      = r_strb[3];
    assign held     = r_db;

endmodule

// File: tb/tb_stopwatch_btn_cond.sv
// Directed bench for stopwatch_btn_cond with DB_CYCLES=4.
module tb_stopwatch_btn_cond;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       b_one = 1'b0;
    logic       b_ten = 1'b0;
    logic       b_pau = 1'b0;
    logic       b_clr = 1'b0;
    logic       onestart;
    logic       tenstart;
    logic       pause;
    logic       clr;
    logic [3:0] held;

    int total  = 0;
    int passed = 0;

    stopwatch_btn_cond #(.DB_CYCLES(DB), .CNT_W(5)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .btn_onestart_raw(b_one),
        .btn_tenstart_raw(b_ten),
        .btn_pause_raw   (b_pau),
        .btn_clr_raw     (b_clr),
        .onestart        (onestart),
        .tenstart        (tenstart),
        .pause           (pause),
        .clr             (clr),
        .held            (held)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] strb();
        return {clr, pause, tenstart, onestart};
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Inputs were just changed; edge j=0 is the first one to sample them.
    task automatic window(input string tag, input logic [3:0] h0,
                          input logic [3:0] h1, input logic [3:0] s,
                          input int n);
        for (int j = 0; j < n; j++) begin
            cyc();
            chk({tag, "_held"}, held, (j >= DB + 1) ? h1 : h0);
            chk({tag, "_strb"}, strb(), (j == DB + 2) ? s : 4'b0000);
            chk({tag, "_onehot"}, {3'b000, $countones(strb()) <= 1},
                4'b0001);
        end
    endtask

    initial begin
        cyc();
        chk("rst_held", held, 4'b0000);
        chk("rst_strb", strb(), 4'b0000);
        b_pau = 1'b1;
        cyc();
        chk("rst_held_btn", held, 4'b0000);
        chk("rst_strb_btn", strb(), 4'b0000);
        b_pau = 1'b0;
        cyc();
        n_rst = 1'b1;
        cyc();

        b_pau = 1'b1;
        window("pause", 4'b0000, 4'b0100, 4'b0100, 50);
        b_pau = 1'b0;
        window("pause_rel", 4'b0100, 4'b0000, 4'b0000, 10);

        b_one = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            b_one = ~b_one;
            chk("bounce_held", held, 4'b0000);
            chk("bounce_strb", strb(), 4'b0000);
        end
        b_one = 1'b1;
        window("bounce", 4'b0000, 4'b0001, 4'b0001, 12);
        b_one = 1'b0;
        window("bounce_rel", 4'b0001, 4'b0000, 4'b0000, 10);

        b_clr = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
        end
        b_clr = 1'b0;
        window("glitch", 4'b0000, 4'b0000, 4'b0000, 12);

        b_ten = 1'b1;
        b_clr = 1'b1;
        window("simul", 4'b0000, 4'b1010, 4'b1000, 12);
        b_clr = 1'b0;
        window("clr_rel", 4'b1010, 4'b0010, 4'b0000, 10);
        b_ten = 1'b0;
        window("ten_rel", 4'b0010, 4'b0000, 4'b0000, 10);

        b_one = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            chk("pre_rst_strb", strb(), 4'b0000);
        end
        n_rst = 1'b0;
        #1;
        chk("mid_rst_held", held, 4'b0000);
        chk("mid_rst_strb", strb(), 4'b0000);
        cyc();
        chk("mid_rst_held2", held, 4'b0000);
        chk("mid_rst_strb2", strb(), 4'b0000);
        cyc();
        n_rst = 1'b1;
        window("post_rst", 4'b0000, 4'b0001, 4'b0001, 14);
        b_one = 1'b0;
        window("post_rst_rel", 4'b0001, 4'b0000, 4'b0000, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
